ysyx_040729_exe_muldiv: RTL and testbench

Iterative RV64M multiply/divide unit, instantiated beside the single-cycle EXE ALU. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms. It computes one bit per cycle and handles divide-by-zero and signed overflow as fast paths. A valid/ready handshake lets the pipeline stall EXE while the unit is busy; a flush input kills an in-flight operation.

---
 rtl/ysyx_040729_exe_muldiv_if.sv | 27 ++
 rtl/ysyx_040729_exe_muldiv.sv | 171 +++++++++++++++++
 tb/tb_ysyx_040729_exe_muldiv.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_040729_exe_muldiv_if.sv
// Request/response bundle between the EXE stage and the iterative mul/div unit.
// master = pipeline side, slave = the mul/div unit.
interface ysyx_040729_exe_muldiv_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            func3;
  logic                  word;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  busy;

  modport master (
    output in_valid, func3, word, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, func3, word, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/ysyx_040729_exe_muldiv.sv
// Iterative RV64M multiply/divide unit: one product/quotient bit per cycle,
// divide-by-zero and signed overflow resolved in a single cycle.
//
// state | meaning
// IDLE  | ready for a request, no result pending
// CALC  | shift-add multiply or restoring divide in progress
// DONE  | result_o valid, waiting for out_ready
module ysyx_040729_exe_muldiv #(
  parameter int DATA_WIDTH = 64,
  parameter int W_OPS      = 1
) (
  input logic                     clock,
  input logic                     reset,
  ysyx_040729_exe_muldiv_if.slave io
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   shreg;     // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [DW-1:0]   rem;       // partial remainder
  logic [2*DW-1:0] mcnd;      // shifted multiplicand; divisor lives in the low half
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   result;
  logic            out_valid;
  logic            op_div, op_rem, op_high, op_word, neg;

  function automatic logic [DW-1:0] sx32(input logic [31:0] v);
    return {{(DW-32){v[31]}}, v};
  endfunction

  // request decode: operand extension, magnitudes and fast-path detection
  logic          w_in, is_div_in, rem_in, high_in, s1_in, s2_in;
  logic          a_neg, b_neg, dz, ovf;
  logic [DW-1:0] a_ext, b_ext, a_mag, b_mag, div_ext, fast_res;

  always_comb begin
    w_in      = io.word & (W_OPS != 0);
    is_div_in = io.func3[2];
    rem_in    = io.func3[2] & io.func3[1];
    // word forms of MULH/MULHSU/MULHU collapse to MULW, so only low bits matter
    high_in   = ~io.func3[2] & (io.func3[1:0] != 2'b00) & ~w_in;
    s1_in     = (io.func3 == 3'b001) | (io.func3 == 3'b010) |
                (io.func3 == 3'b100) | (io.func3 == 3'b110);
    s2_in     = (io.func3 == 3'b001) | (io.func3 == 3'b100) | (io.func3 == 3'b110);
    if (w_in && !is_div_in) begin
      s1_in = 1'b0;
      s2_in = 1'b0;
    end
    a_ext = w_in ? (s1_in ? sx32(io.src1[31:0]) : {{(DW-32){1'b0}}, io.src1[31:0]}) : io.src1;
    b_ext = w_in ? (s2_in ? sx32(io.src2[31:0]) : {{(DW-32){1'b0}}, io.src2[31:0]}) : io.src2;
    a_neg = s1_in & a_ext[DW-1];
    b_neg = s2_in & b_ext[DW-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    dz    = (b_ext == '0);
    ovf   = s1_in & s2_in & is_div_in & (b_ext == '1) &
            (w_in ? (io.src1[31:0] == 32'h8000_0000) : (io.src1 == {1'b1, {(DW-1){1'b0}}}));
    div_ext  = w_in ? sx32(io.src1[31:0]) : io.src1;
    fast_res = rem_in ? (dz ? div_ext : '0) : (dz ? '1 : div_ext);
  end

  // one iteration of the datapath
  logic [2*DW-1:0] prod_nxt, mcnd_nxt;
  logic [DW-1:0]   shreg_nxt, rem_nxt;
  logic [DW:0]     trial, diff;

  always_comb begin
    prod_nxt  = prod;
    mcnd_nxt  = mcnd;
    shreg_nxt = shreg;
    rem_nxt   = rem;
    trial     = {rem, shreg[DW-1]};
    diff      = trial - {1'b0, mcnd[DW-1:0]};
    if (op_div) begin
      rem_nxt   = diff[DW] ? trial[DW-1:0] : diff[DW-1:0];
      shreg_nxt = {shreg[DW-2:0], ~diff[DW]};
    end else begin
      if (shreg[0]) prod_nxt = prod + mcnd;
      mcnd_nxt  = mcnd << 1;
      shreg_nxt = shreg >> 1;
    end
  end

  // result formed from the final iteration so it registers on the DONE entry edge
  logic [2*DW-1:0] wide;
  logic [DW-1:0]   sel, calc_res;

  always_comb begin
    wide = op_div ? {{DW{1'b0}}, (op_rem ? rem_nxt : shreg_nxt)} : prod_nxt;
    if (neg) wide = -wide;
    sel      = op_high ? wide[2*DW-1:DW] : wide[DW-1:0];
    calc_res = op_word ? sx32(sel[31:0]) : sel;
  end

  // control FSM and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      rem       <= '0;
      mcnd      <= '0;
      prod      <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      op_div    <= 1'b0;
      op_rem    <= 1'b0;
      op_high   <= 1'b0;
      op_word   <= 1'b0;
      neg       <= 1'b0;
    end else if (io.flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            op_div  <= is_div_in;
            op_rem  <= rem_in;
            op_high <= high_in;
            op_word <= w_in;
            // remainder follows the dividend; product/quotient follow the sign mix
            neg     <= rem_in ? a_neg : (a_neg ^ b_neg);
            if (is_div_in && (dz || ovf)) begin
              result    <= fast_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              prod  <= '0;
              rem   <= '0;
              mcnd  <= is_div_in ? {{DW{1'b0}}, b_mag} : {{DW{1'b0}}, a_mag};
              // word dividends are left-aligned so the MSB-first loop runs 32 steps
              shreg <= is_div_in ? (w_in ? (a_mag << 32) : a_mag) : b_mag;
              cnt   <= w_in ? CW'(32) : CW'(DW);
              state <= CALC;
            end
          end
        end
        CALC: begin
          prod  <= prod_nxt;
          mcnd  <= mcnd_nxt;
          shreg <= shreg_nxt;
          rem   <= rem_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= calc_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.busy      = (state != IDLE);
  assign io.out_valid = out_valid;
  assign io.result    = result;
endmodule

// File: tb/tb_ysyx_040729_exe_muldiv.sv
// Directed bench for the iterative mul/div unit with a native-arithmetic model.
module tb_ysyx_040729_exe_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ysyx_040729_exe_muldiv_if #(.DATA_WIDTH(64)) io ();

  ysyx_040729_exe_muldiv #(.DATA_WIDTH(64), .W_OPS(1)) dut (
    .clock(clk),
    .reset(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_res = '0;
  logic [63:0] last_res = '0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: RISC-V M semantics straight from native arithmetic
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] x, y, p;
    longint sa, sb;
    int sa32, sb32;
    logic [31:0] r32;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    x = '0; y = '0; p = '0; r = '0; r32 = '0;
    if (w) begin
      case (f3)
        3'b100: r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF :
                      (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) ? a[31:0] : 32'(sa32 / sb32);
        3'b101: r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
        3'b110: r32 = (b[31:0] == 0) ? a[31:0] :
                      (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa32 % sb32);
        3'b111: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f3)
        3'b000: r = a * b;
        3'b001: begin x = {{64{a[63]}}, a}; y = {{64{b[63]}}, b}; p = x * y; r = p[127:64]; end
        3'b010: begin x = {{64{a[63]}}, a}; y = {64'h0, b};       p = x * y; r = p[127:64]; end
        3'b011: begin x = {64'h0, a};       y = {64'h0, b};       p = x * y; r = p[127:64]; end
        3'b100: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF :
                    (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) ? a : 64'(sa / sb);
        3'b101: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
        3'b110: r = (b == 0) ? a :
                    (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) ? 64'h0 : 64'(sa % sb);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  // compare process: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (rst_n && io.out_valid) begin
      if (chk_en) check("result_vs_model", io.result, exp_res);
      else begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got 1 expected 0");
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input int hold);
    int cyc;
    bit rdy_hi;
    @(negedge clk);
    check({name, "_ready_idle"}, io.in_ready, 1'b1);
    io.func3 = f3; io.word = w; io.src1 = a; io.src2 = b; io.in_valid = 1'b1;
    exp_res = model(f3, w, a, b);
    chk_en  = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    cyc = 1; rdy_hi = 1'b0;
    while (!io.out_valid && cyc < 200) begin
      if (io.in_ready) rdy_hi = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
    if (exp_lat > 1) check({name, "_ready_low"}, {63'h0, rdy_hi}, 64'h0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, io.out_valid, 1'b1);
      check({name, "_hold_result"}, io.result, exp_res);
    end
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    check({name, "_post_valid"}, io.out_valid, 1'b0);
    check({name, "_post_busy"}, io.busy, 1'b0);
    last_res = exp_res;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    io.in_valid = 1'b0; io.func3 = '0; io.word = 1'b0; io.src1 = '0; io.src2 = '0;
    io.flush = 1'b0; io.out_ready = 1'b0;

    #12;
    check("rst_busy", io.busy, 1'b0);
    check("rst_valid", io.out_valid, 1'b0);
    check("rst_result", io.result, 64'h0);
    check("rst_ready", io.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // pin the model against hand-computed values
    check("pin_mul",    model(3'b000, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    check("pin_mulh",   model(3'b001, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000), 64'h4000_0000_0000_0000);
    check("pin_mulhu",  model(3'b011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'd1);
    check("pin_mulhsu", model(3'b010, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_div0",   model(3'b100, 0, 64'd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_rem0",   model(3'b110, 0, 64'd5, 64'd0), 64'd5);
    check("pin_divw",   model(3'b100, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("pin_remw",   model(3'b110, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    check("pin_mulw",   model(3'b000, 1, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    check("pin_divu",   model(3'b101, 0, 64'd100, 64'd7), 64'd14);
    check("pin_remu",   model(3'b111, 0, 64'd100, 64'd7), 64'd2);

    run_op("mul",    3'b000, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("mulh",   3'b001, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65, 0);
    run_op("mulhu",  3'b011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 0);
    run_op("mulhsu", 3'b010, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 0);
    run_op("mulh_mix", 3'b001, 0, 64'hFFFF_FFFF_0000_1234, 64'h0123_4567_89AB_CDEF, 65, 0);
    run_op("div0",   3'b100, 0, 64'd5, 64'd0, 1, 0);
    run_op("rem0",   3'b110, 0, 64'd5, 64'd0, 1, 0);
    run_op("divu0",  3'b101, 0, 64'd9, 64'd0, 1, 0);
    run_op("div_ovf", 3'b100, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem_ovf", 3'b110, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("div_neg", 3'b100, 0, -64'sd100, 64'd7, 65, 0);
    run_op("rem_neg", 3'b110, 0, -64'sd100, 64'd7, 65, 0);
    run_op("divu_big", 3'b101, 0, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_1234_5677, 65, 0);
    run_op("divw",   3'b100, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 33, 0);
    run_op("remw",   3'b110, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 33, 0);
    run_op("mulw",   3'b000, 1, 64'h7FFF_FFFF, 64'd2, 33, 0);
    run_op("mulhw_as_mulw", 3'b011, 1, 64'hABCD_0000_8000_0001, 64'h3, 33, 0);
    run_op("remuw",  3'b111, 1, 64'h1234_5678_FFFF_FFF0, 64'hFFFF_FFFF_0000_0007, 33, 0);
    run_op("divw_ovf", 3'b100, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 0);
    run_op("backpressure", 3'b001, 0, -64'sd3, 64'd5, 65, 5);

    // flush at CALC cycle 10 while a fast-path request is also offered
    @(negedge clk);
    io.func3 = 3'b101; io.word = 1'b0; io.src1 = 64'd100; io.src2 = 64'd7; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    chk_en = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    io.func3 = 3'b100; io.src1 = 64'd5; io.src2 = 64'd0;
    io.in_valid = 1'b1; io.flush = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0; io.flush = 1'b0;
    check("flush_busy", io.busy, 1'b0);
    check("flush_valid", io.out_valid, 1'b0);
    check("flush_ready", io.in_ready, 1'b1);
    check("flush_result_kept", io.result, last_res);
    repeat (70) @(posedge clk);
    #1;
    check("flush_no_result", io.out_valid, 1'b0);
    check("flush_idle", io.busy, 1'b0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    io.func3 = 3'b000; io.src1 = 64'd11; io.src2 = 64'd13; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", io.busy, 1'b0);
    check("async_rst_valid", io.out_valid, 1'b0);
    check("async_rst_result", io.result, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_after_rst", 3'b101, 0, 64'd100, 64'd7, 65, 0);
    run_op("remu_after_rst", 3'b111, 0, 64'd100, 64'd7, 65, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
